// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory fetch arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imem_arb_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   localparam int NUM_REQ_DEF = 8;
   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;

   // Width of a requester index / priority pointer (at least one bit)
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/imem_rr_pick.sv
// Combinational winner select: first requester at or after ptr (wrapping), mask removes bits.
// Latency: zero cycles, purely combinational.
// Backpressure: none; with no unmasked request gnt is zero and idx is 0.
module imem_rr_pick
   import imem_arb_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   localparam int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   idx
);

   logic [NUM_REQ-1:0] eff_req;
   logic [PTR_W:0]     cand;
   logic               found;

   assign eff_req = req & ~mask;

   // Scan from ptr upward with wrap; the first eligible requester wins
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_REQ)) begin
            cand = cand - (PTR_W+1)'(NUM_REQ);
         end
         if (!found && eff_req[cand[PTR_W-1:0]]) begin
            gnt[cand[PTR_W-1:0]] = 1'b1;
            idx                  = cand[PTR_W-1:0];
            found                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one combinational instruction memory among NUM_REQ cores; IMEM_ARB_FIXED_PRIORITY_EN selects fixed priority.
// Latency: Req seen in IDLE at t -> Grant/MemAddress at t+1 -> RspValid/RspInstruction at t+2.
// Backpressure: cores hold Req/ReqAddr until their RspValid; the served core is masked for one arbitration.
module imem_fetch_arbiter
   import imem_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic [NUM_REQ-1:0]        Req,
   input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
   output logic [NUM_REQ-1:0]        Grant,
   output logic [NUM_REQ-1:0]        RspValid,
   output logic [DATA_W-1:0]         RspInstruction,
   output logic [ADDR_W-1:0]         MemAddress,
   input  logic [DATA_W-1:0]         MemInstruction,
   output logic                      Busy
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  rsp_q, rsp_d;

   logic [NUM_REQ-1:0] pick_mask;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   pick_ptr;
   logic               pick_any;

`ifdef IMEM_ARB_FIXED_PRIORITY_EN
   // No pointer: the scan always starts at index 0, so the lowest eligible index wins
   logic unused_pick_idx;
   assign pick_ptr        = '0;
   assign unused_pick_idx = ^pick_idx;
`else
   logic [PTR_W-1:0] ptr_q, ptr_d;
   assign pick_ptr = ptr_q;
`endif

   // Core just served gets no second shot straight out of RESP
   assign pick_mask = (state_q == RESP) ? win_oh_q : '0;
   assign pick_any  = |(Req & ~pick_mask);

   imem_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req  (Req),
      .mask (pick_mask),
      .ptr  (pick_ptr),
      .gnt  (pick_gnt),
      .idx  (pick_idx)
   );

   // Next-state: arbitrate in IDLE/RESP, sample memory data at the end of ISSUE
   always_comb begin
      state_d  = state_q;
      win_oh_d = win_oh_q;
      addr_d   = addr_q;
      rsp_d    = rsp_q;
`ifndef IMEM_ARB_FIXED_PRIORITY_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         IDLE, RESP: begin
            if (pick_any) begin
               state_d  = ISSUE;
               win_oh_d = pick_gnt;
               addr_d   = ReqAddr[pick_idx*ADDR_W +: ADDR_W];
`ifndef IMEM_ARB_FIXED_PRIORITY_EN
               ptr_d    = (pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            rsp_d   = MemInstruction;
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset drops any in-flight fetch
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         win_oh_q <= '0;
         addr_q   <= '0;
         rsp_q    <= '0;
`ifndef IMEM_ARB_FIXED_PRIORITY_EN
         ptr_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         win_oh_q <= win_oh_d;
         addr_q   <= addr_d;
         rsp_q    <= rsp_d;
`ifndef IMEM_ARB_FIXED_PRIORITY_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign Grant          = (state_q == ISSUE) ? win_oh_q : '0;
   assign RspValid       = (state_q == RESP)  ? win_oh_q : '0;
   assign MemAddress     = addr_q;
   assign RspInstruction = rsp_q;
   assign Busy           = (state_q != IDLE);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a combinational memory model.
// Latency: checks Grant at t+1 and RspValid at t+2 relative to the request cycle.
// Backpressure: cores hold Req until RspValid, matching the arbiter's contract.
module tb_imem_fetch_arbiter;

   logic         Clk = 1'b0;
   logic         Rst_n;
   logic [7:0]   Req;
   logic [255:0] ReqAddr;
   logic [7:0]   Grant;
   logic [7:0]   RspValid;
   logic [31:0]  RspInstruction;
   logic [31:0]  MemAddress;
   logic [31:0]  MemInstruction;
   logic         Busy;

   int tests = 0;
   int fails = 0;

   imem_fetch_arbiter dut (
      .Clk            (Clk),
      .Rst_n          (Rst_n),
      .Req            (Req),
      .ReqAddr        (ReqAddr),
      .Grant          (Grant),
      .RspValid       (RspValid),
      .RspInstruction (RspInstruction),
      .MemAddress     (MemAddress),
      .MemInstruction (MemInstruction),
      .Busy           (Busy)
   );

   always #5 Clk = ~Clk;

   // Word-addressed memory: word 4 holds DEADBEEF, others a pattern of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a[31:2] == 30'd4) ? 32'hDEAD_BEEF : (32'h5A00_0000 ^ {a[31:2], 2'b00});
   endfunction

   always_comb MemInstruction = mem_word(MemAddress);

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [31:0] a);
      ReqAddr[i*32 +: 32] = a;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input logic [7:0] g, input logic [7:0] v, input logic b);
      chk({tag, ".grant"}, 64'(Grant), 64'(g));
      chk({tag, ".rspvalid"}, 64'(RspValid), 64'(v));
      chk({tag, ".busy"}, 64'(Busy), 64'(b));
   endtask

   initial begin
      logic [7:0] oh;
      int         core;

      Rst_n   = 1'b0;
      Req     = '0;
      ReqAddr = '0;
      #1;
      chk_cyc("reset", 8'h00, 8'h00, 1'b0);
      chk("reset.addr", 64'(MemAddress), 64'h0);
      chk("reset.instr", 64'(RspInstruction), 64'h0);
      step();
      step();
      Rst_n = 1'b1;
      step();
      chk_cyc("idle_noreq", 8'h00, 8'h00, 1'b0);

      // Single request from core 2, word 4
      Req = 8'h04;
      set_addr(2, 32'h0000_0010);
      step();
      chk_cyc("single.issue", 8'h04, 8'h00, 1'b1);
      chk("single.memaddr", 64'(MemAddress), 64'h10);
      step();
      chk_cyc("single.resp", 8'h00, 8'h04, 1'b1);
      chk("single.instr", 64'(RspInstruction), 64'hDEAD_BEEF);
      Req = 8'h00;
      step();
      chk_cyc("single.idle", 8'h00, 8'h00, 1'b0);
      chk("single.addr_hold", 64'(MemAddress), 64'h10);
      chk("single.instr_hold", 64'(RspInstruction), 64'hDEAD_BEEF);

      // Misaligned address; Req drops and ReqAddr changes after latch
      Req = 8'h40;
      set_addr(6, 32'h1234_5677);
      step();
      chk_cyc("misalign.issue", 8'h40, 8'h00, 1'b1);
      chk("misalign.memaddr", 64'(MemAddress), 64'h1234_5677);
      Req = 8'h00;
      set_addr(6, 32'hFFFF_FFF0);
      step();
      chk_cyc("misalign.resp", 8'h00, 8'h40, 1'b1);
      chk("misalign.instr", 64'(RspInstruction), 64'(mem_word(32'h1234_5677)));
      chk("misalign.addr_hold", 64'(MemAddress), 64'h1234_5677);
      step();
      chk_cyc("misalign.idle", 8'h00, 8'h00, 1'b0);

      // Reset during ISSUE for core 5
      Req = 8'h20;
      set_addr(5, 32'h0000_0054);
      step();
      chk_cyc("rst.issue", 8'h20, 8'h00, 1'b1);
      #2;
      Rst_n = 1'b0;
      #1;
      chk_cyc("rst.async", 8'h00, 8'h00, 1'b0);
      chk("rst.async_addr", 64'(MemAddress), 64'h0);
      chk("rst.async_instr", 64'(RspInstruction), 64'h0);
      for (int i = 0; i < 8; i++) set_addr(i, 32'h100 + 32'(i*4));
`ifdef IMEM_ARB_FIXED_PRIORITY_EN
      Req = 8'h81;
`else
      Req = 8'hFF;
`endif
      step();
      chk_cyc("rst.held", 8'h00, 8'h00, 1'b0);
      #3;
      Rst_n = 1'b1;
      step();

`ifdef IMEM_ARB_FIXED_PRIORITY_EN
      // Cores 0 and 7 alternate thanks to the RESP mask, then 0x06 serves 1 then 2
      for (int n = 0; n < 6; n++) begin
         core = (n < 4) ? ((n % 2 == 0) ? 0 : 7) : n - 3;
         oh   = 8'b1 << core;
         chk_cyc($sformatf("fixed%0d.issue", n), oh, 8'h00, 1'b1);
         chk($sformatf("fixed%0d.addr", n), 64'(MemAddress), 64'(32'h100 + 32'(core*4)));
         step();
         chk_cyc($sformatf("fixed%0d.resp", n), 8'h00, oh, 1'b1);
         chk($sformatf("fixed%0d.instr", n), 64'(RspInstruction), 64'(mem_word(32'h100 + 32'(core*4))));
         if (n == 3) Req = 8'h06;
         if (n == 5) Req = 8'h00;
         step();
      end
`else
      // All requesters held: grant order 0..7,0 with one response every 2 cycles
      for (int n = 0; n < 9; n++) begin
         core = n % 8;
         oh   = 8'b1 << core;
         chk_cyc($sformatf("rr%0d.issue", n), oh, 8'h00, 1'b1);
         chk($sformatf("rr%0d.addr", n), 64'(MemAddress), 64'(32'h100 + 32'(core*4)));
         step();
         chk_cyc($sformatf("rr%0d.resp", n), 8'h00, oh, 1'b1);
         chk($sformatf("rr%0d.instr", n), 64'(RspInstruction), 64'(mem_word(32'h100 + 32'(core*4))));
         if (n == 8) Req = 8'h00;
         step();
      end
`endif
      chk_cyc("burst.idle", 8'h00, 8'h00, 1'b0);

      // Core 3 alone: IDLE -> ISSUE -> RESP every 3 cycles
      Req = 8'h08;
      set_addr(3, 32'h0000_0030);
      for (int r = 0; r < 2; r++) begin
         step();
         chk_cyc($sformatf("solo%0d.issue", r), 8'h08, 8'h00, 1'b1);
         step();
         chk_cyc($sformatf("solo%0d.resp", r), 8'h00, 8'h08, 1'b1);
         if (r == 0) begin
            step();
            chk_cyc("solo0.idle", 8'h00, 8'h00, 1'b0);
         end
      end

      // Back-to-back from RESP to a different core, then back to core 3
      Req = 8'h09;
      set_addr(0, 32'h0000_0004);
      step();
      chk_cyc("b2b.issue0", 8'h01, 8'h00, 1'b1);
      step();
      chk_cyc("b2b.resp0", 8'h00, 8'h01, 1'b1);
      chk("b2b.instr0", 64'(RspInstruction), 64'(mem_word(32'h4)));
      step();
      chk_cyc("b2b.issue3", 8'h08, 8'h00, 1'b1);
      Req = 8'h00;
      step();
      chk_cyc("b2b.resp3", 8'h00, 8'h08, 1'b1);
      chk("b2b.instr3", 64'(RspInstruction), 64'(mem_word(32'h30)));
      step();
      chk_cyc("b2b.idle", 8'h00, 8'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
